// File: rtl/ft245_stream_bridge.sv
// ft245_stream_bridge: FT245 FIFO handshake to backpressured ingress stream and FIFO-buffered egress stream
module ft245_stream_bridge #(
  parameter int EDEPTH   = 16,
  parameter int RD_PULSE = 2,
  parameter int WR_PULSE = 2,
  parameter int GAP_CYC  = 1
) (
  input  logic                        Clk,
  input  logic                        ARst,
  input  logic                        RXFn,
  input  logic                        TXEn,
  output logic                        RDn,
  output logic                        WRn,
  output logic                        OEn,
  input  logic [7:0]                  DIN,
  output logic [7:0]                  DOUT,
  output logic                        DOE,
  output logic                        IValid,
  output logic [7:0]                  ID,
  input  logic                        IReady,
  input  logic                        EValid,
  input  logic [7:0]                  ED,
  output logic [$clog2(EDEPTH+1)-1:0] EFill,
  output logic                        Ovf
);
  localparam int AW = $clog2(EDEPTH);
  localparam int FW = $clog2(EDEPTH + 1);
  localparam int PMAX = RD_PULSE > WR_PULSE ? RD_PULSE : WR_PULSE;
  localparam int CMAX = PMAX > GAP_CYC ? PMAX : GAP_CYC;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, RD_OE, RD_STB, WR_SETUP, WR_STB, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            last_wr;
  logic            rd_ok, wr_ok, rd_cap, pop, push, full;
  logic [7:0]      mem [EDEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;

  assign rd_ok  = ~RXFn & ~IValid;
  assign wr_ok  = ~TXEn & (EFill != '0);
  assign rd_cap = state == RD_STB && cnt == CW'(RD_PULSE - 1);
  assign pop    = state == WR_STB && cnt == CW'(WR_PULSE - 1);
  assign full   = EFill == FW'(EDEPTH);
  assign push   = EValid & (~full | pop);

  // cnt restarts on every state change and times the multi-cycle states
  always_ff @(posedge Clk) begin
    if (ARst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_wr <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? '0 : cnt + 1'b1;
      if (state == IDLE && state_n != IDLE) last_wr <= state_n == WR_SETUP;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = rd_ok & (~wr_ok | last_wr) ? RD_OE : wr_ok ? WR_SETUP : IDLE;
      RD_OE:    state_n = RD_STB;
      RD_STB:   state_n = rd_cap ? GAP : RD_STB;
      WR_SETUP: state_n = WR_STB;
      WR_STB:   state_n = pop ? GAP : WR_STB;
      GAP:      state_n = cnt == CW'(GAP_CYC - 1) ? IDLE : GAP;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    OEn  = ~(state == RD_OE || state == RD_STB);
    RDn  = state != RD_STB;
    WRn  = state != WR_STB;
    DOE  = state == WR_SETUP || state == WR_STB;
    DOUT = DOE ? mem[rd_ptr] : 8'h00;
  end

  always_ff @(posedge Clk) begin
    if (ARst) begin
      IValid <= 1'b0;
      ID     <= 8'h00;
      rd_ptr <= '0;
      wr_ptr <= '0;
      EFill  <= '0;
      Ovf    <= 1'b0;
    end else begin
      if (rd_cap) begin
        IValid <= 1'b1;
        ID     <= DIN;
      end else if (IValid & IReady) IValid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      EFill <= EFill + FW'(push) - FW'(pop);
      if (EValid & ~push) Ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= ED;
  end
endmodule

// File: tb/tb_ft245_stream_bridge.sv
// tb_ft245_stream_bridge: directed vector table plus multi-cycle sequences for ft245_stream_bridge
module tb_ft245_stream_bridge;
  logic       Clk = 1'b0, ARst = 1'b0;
  logic       RXFn, TXEn = 1'b1, RDn, WRn, OEn, DOE, IValid, IReady = 1'b0, EValid = 1'b0, Ovf;
  logic [7:0] DIN, DOUT, ID, ED = 8'h00;
  logic [4:0] EFill;

  logic       rx_model = 1'b0, rxfn_v = 1'b1;
  logic [7:0] din_v = 8'h00;
  logic [7:0] rx_q [16];
  int         rx_idx = 0, rx_n = 0;
  logic [7:0] tx_log [$];
  logic       order [$];
  logic [7:0] got [$];
  int         n_cmp = 0, n_bad = 0;

  typedef struct packed {
    logic        rxfn;
    logic        txen;
    logic        evalid;
    logic [7:0]  ed;
    logic [26:0] exp;
  } vec_t;
  vec_t tbl [11];

  assign RXFn = rx_model ? (rx_idx >= rx_n) : rxfn_v;
  assign DIN  = rx_model ? rx_q[rx_idx[3:0]] : din_v;

  ft245_stream_bridge dut (
    .Clk(Clk), .ARst(ARst), .RXFn(RXFn), .TXEn(TXEn), .RDn(RDn), .WRn(WRn), .OEn(OEn),
    .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .IValid(IValid), .ID(ID), .IReady(IReady),
    .EValid(EValid), .ED(ED), .EFill(EFill), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  always @(posedge RDn) if (rx_model) rx_idx++;
  always @(negedge OEn) order.push_back(1'b0);
  always @(negedge WRn) begin
    tx_log.push_back(DOUT);
    order.push_back(1'b1);
  end

  always @(negedge Clk) begin
    if (!ARst) begin
      n_cmp++;
      if ((!RDn && !WRn) || (!OEn && DOE)) begin
        n_bad++;
        $display("FAIL invariant: RDn=%b WRn=%b OEn=%b DOE=%b", RDn, WRn, OEn, DOE);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [26:0] mk(logic rdn, logic wrn, logic oen, logic doe, logic iv,
                                     logic [7:0] id, logic [7:0] dout, logic [4:0] fill, logic ovf);
    return {rdn, wrn, oen, doe, iv, id, dout, fill, ovf};
  endfunction

  function automatic logic [26:0] outs();
    return {RDn, WRn, OEn, DOE, IValid, ID, DOUT, EFill, Ovf};
  endfunction

  function automatic vec_t v(logic rxfn, logic txen, logic ev, logic [7:0] ed, logic [26:0] exp);
    return {rxfn, txen, ev, ed, exp};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    rx_model = 1'b0; rxfn_v = 1'b1; TXEn = 1'b1; IReady = 1'b0; EValid = 1'b0;
    ARst = 1'b1;
    tick();
    ARst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    EValid = 1'b1; ED = b;
    tick();
    EValid = 1'b0;
  endtask

  initial begin
    tbl[0]  = v(0, 1, 0, 8'h00, mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl[1]  = v(1, 1, 0, 8'h00, mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl[2]  = v(1, 1, 0, 8'h00, mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl[3]  = v(1, 1, 0, 8'h00, mk(1, 1, 1, 0, 1, 8'hA5, 8'h00, 0, 0));
    tbl[4]  = v(1, 1, 0, 8'h00, mk(1, 1, 1, 0, 0, 8'hA5, 8'h00, 0, 0));
    tbl[5]  = v(1, 1, 1, 8'h3C, mk(1, 1, 1, 0, 0, 8'hA5, 8'h00, 1, 0));
    tbl[6]  = v(1, 0, 0, 8'h00, mk(1, 1, 1, 1, 0, 8'hA5, 8'h3C, 1, 0));
    tbl[7]  = v(1, 1, 0, 8'h00, mk(1, 0, 1, 1, 0, 8'hA5, 8'h3C, 1, 0));
    tbl[8]  = v(1, 1, 0, 8'h00, mk(1, 0, 1, 1, 0, 8'hA5, 8'h3C, 1, 0));
    tbl[9]  = v(1, 1, 0, 8'h00, mk(1, 1, 1, 0, 0, 8'hA5, 8'h00, 0, 0));
    tbl[10] = v(1, 1, 0, 8'h00, mk(1, 1, 1, 0, 0, 8'hA5, 8'h00, 0, 0));

    // reset and quiet idle
    do_reset();
    chk("reset", outs(), mk(1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle%0d", i), {RDn, WRn, OEn, DOE, IValid, EFill}, {5'b11100, 5'd0});
    end

    // single read then single write, cycle by cycle
    din_v = 8'hA5; IReady = 1'b1;
    for (int i = 0; i < 11; i++) begin
      rxfn_v = tbl[i].rxfn; TXEn = tbl[i].txen; EValid = tbl[i].evalid; ED = tbl[i].ed;
      tick();
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    EValid = 1'b0; rxfn_v = 1'b1; TXEn = 1'b1;

    // ingress backpressure
    do_reset();
    rx_q[0] = 8'h01; rx_q[1] = 8'h02; rx_q[2] = 8'h03;
    rx_idx = 0; rx_n = 3; rx_model = 1'b1;
    repeat (30) tick();
    chk("bp_ivalid", IValid, 1);
    chk("bp_id", ID, 8'h01);
    chk("bp_reads", rx_idx, 1);
    chk("bp_rdn", RDn, 1);
    got.delete();
    IReady = 1'b1;
    for (int c = 0; c < 100 && got.size() < 3; c++) begin
      if (IValid && IReady) got.push_back(ID);
      tick();
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("bp_byte%0d", i), got[i], i + 1);
    rx_model = 1'b0;

    // egress fill and overflow
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i));
    chk("ovf_fill", EFill, 16);
    chk("ovf_flag", Ovf, 1);
    tx_log.delete();
    TXEn = 1'b0;
    for (int c = 0; c < 300 && EFill != 0; c++) tick();
    repeat (5) tick();
    chk("drain_count", tx_log.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("drain%0d", i), tx_log[i], i);
    chk("drain_fill", EFill, 0);
    chk("drain_ovf", Ovf, 1);
    TXEn = 1'b1;

    // reset in the middle of a write strobe
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    TXEn = 1'b0;
    for (int c = 0; c < 20 && WRn; c++) tick();
    chk("mid_wrn_low", WRn, 0);
    chk("mid_fill", EFill, 5);
    ARst = 1'b1;
    tick();
    chk("mid_reset", {RDn, WRn, OEn, DOE, IValid, EFill, Ovf}, {5'b11100, 5'd0, 1'b0});
    ARst = 1'b0;
    tx_log.delete();
    repeat (20) tick();
    chk("post_no_write", tx_log.size(), 0);
    chk("post_fill", EFill, 0);
    push(8'h77);
    repeat (10) tick();
    chk("post_write_count", tx_log.size(), 1);
    chk("post_write_byte", tx_log[0], 8'h77);

    // read/write contention alternates fairly
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    rx_q[0] = 8'h11; rx_q[1] = 8'h22; rx_q[2] = 8'h33; rx_q[3] = 8'h44;
    rx_idx = 0; rx_n = 4; IReady = 1'b1;
    order.delete();
    rx_model = 1'b1; TXEn = 1'b0;
    for (int c = 0; c < 200 && order.size() < 8; c++) tick();
    chk("cont_count", order.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("cont_order%0d", i), order[i], i % 2);
    rx_model = 1'b0; TXEn = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
